// File: rtl/parallel2serial_stream.sv
// Double-buffered parallel-to-serial converter with start/end framing.
// Optional macro PARITY_STREAM_EN appends an even-parity bit period to every word.
module parallel2serial_stream #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic             parallel_begin,
  output logic             ready,
  output logic             d,
  output logic             serial_valid,
  output logic             serial_start,
  output logic             serial_end,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PARITY_STREAM_EN
    ,
    PAR   = 2'd2
`endif
  } state_t;

`ifdef PARITY_STREAM_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   word_r, word_s;
  logic [WIDTH-1:0]   hold_r, hold_s;
  logic               hold_full_r, hold_full_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic               accept_s, wrap_s, word_done_s;
  logic [CNT_W-1:0]   idx_s;
  logic               valid_s, bit_s, start_s, end_s;
  logic               d_r, valid_r, start_r, end_r;

  // Next-state for shifter, divider, bit counter and holding buffer
  always_comb begin
    state_s     = state_r;
    word_s      = word_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    cnt_s       = cnt_r;
    div_s       = div_r;
    word_done_s = 1'b0;
    accept_s    = parallel_begin && !hold_full_r;
    wrap_s      = (div_r == LAST_DIV);

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SHIFT;
          word_s  = a;
          cnt_s   = CNT_W'(0);
          div_s   = DIV_W'(0);
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (!wrap_s) begin
          div_s = div_r + DIV_W'(1);
        end else if (cnt_r != LAST_BIT) begin
          cnt_s = cnt_r + CNT_W'(1);
          div_s = DIV_W'(0);
        end else begin
`ifdef PARITY_STREAM_EN
          state_s = PAR;
          div_s   = DIV_W'(0);
`else
          word_done_s = 1'b1;
`endif
        end
      end
`ifdef PARITY_STREAM_EN
      PAR: begin
        if (!wrap_s) begin
          div_s = div_r + DIV_W'(1);
        end else begin
          word_done_s = 1'b1;
        end
      end
`endif
      default: state_s = IDLE;
    endcase

    // A finished word hands off to the held word first, then to a same-edge accept
    if (word_done_s) begin
      cnt_s = CNT_W'(0);
      div_s = DIV_W'(0);
      if (hold_full_r) begin
        word_s      = hold_r;
        hold_full_s = 1'b0;
        state_s     = SHIFT;
      end else if (accept_s) begin
        word_s  = a;
        state_s = SHIFT;
      end else begin
        state_s = IDLE;
      end
    end else if (accept_s && (state_r != IDLE)) begin
      hold_s      = a;
      hold_full_s = 1'b1;
    end else begin
      hold_s = hold_r;
    end
  end

  // Output bit and framing derived from the post-edge shifter position
  always_comb begin
    valid_s = (state_s != IDLE);
    if (MSB_FIRST != 0) begin
      idx_s = LAST_BIT - cnt_s;
    end else begin
      idx_s = cnt_s;
    end
    bit_s   = word_s[idx_s];
    start_s = (state_s == SHIFT) && (cnt_s == CNT_W'(0));
`ifdef PARITY_STREAM_EN
    if (state_s == PAR) begin
      bit_s = even_parity(word_s);
    end else begin
      bit_s = word_s[idx_s];
    end
    end_s = (state_s == PAR);
`else
    end_s = (state_s == SHIFT) && (cnt_s == LAST_BIT);
`endif
  end

  // State and registered serial outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      word_r      <= '0;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      cnt_r       <= CNT_W'(0);
      div_r       <= DIV_W'(0);
      d_r         <= 1'b0;
      valid_r     <= 1'b0;
      start_r     <= 1'b0;
      end_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      word_r      <= word_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      cnt_r       <= cnt_s;
      div_r       <= div_s;
      d_r         <= valid_s & bit_s;
      valid_r     <= valid_s;
      start_r     <= start_s;
      end_r       <= end_s;
    end
  end

  assign ready        = !hold_full_r;
  assign busy         = (state_r != IDLE) || hold_full_r;
  assign d            = d_r;
  assign serial_valid = valid_r;
  assign serial_start = start_r;
  assign serial_end   = end_r;

endmodule
